// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer_if
// Purpose  : Bundles the piso_serializer word handshake and its serial output.
//            slave  - the serializer (accepts words, drives the bitstream)
//            master - the word producer / bitstream consumer
// Signals  : din        parallel word (WIDTH bits)
//            din_valid  din holds a valid word
//            din_ready  serializer can take a word this cycle
//            x          serial data bit
//            x_valid    x carries a valid bit this cycle
//            busy       a word is being shifted out
// Revision : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x,
    output x_valid,
    output busy
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x,
    input  x_valid,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out stage. Takes a WIDTH-bit word over a
//            valid/ready handshake and emits it one bit per clock on x,
//            flagged by x_valid. Words may follow back-to-back with no gap.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous reset, active low (0 = reset)
//            bus  - piso_serializer_if.slave (din, din_valid, din_ready,
//                   x, x_valid, busy)
// Options  : SER_LSB_FIRST_EN - when defined, words leave LSB first
//            (shift right); otherwise MSB first (shift left).
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  wire                   clk,
  input  wire                   rst,
  piso_serializer_if.slave      bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_x;
  logic             r_x_valid;

  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_first_bit;

  assign w_last  = (r_cnt == C_LAST);

  // Ready in IDLE, or during the last bit of a word so the next word can
  // follow without a gap. Gated by rst so nothing is offered in reset.
  assign w_ready  = rst && ((r_state == S_IDLE) ||
                            ((r_state == S_SHIFT) && w_last));
  assign w_accept = w_ready && bus.din_valid;

`ifdef SER_LSB_FIRST_EN
  assign w_first_bit = bus.din[0];
`else
  assign w_first_bit = bus.din[WIDTH-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sreg    <= bus.din;
            r_x       <= w_first_bit;
            r_x_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (w_last) begin
            if (w_accept) begin
              // Reload in the same edge: next word's first bit follows
              // the previous word's last bit directly.
              r_sreg    <= bus.din;
              r_x       <= w_first_bit;
              r_x_valid <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_x       <= 1'b0;
              r_x_valid <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end
          end else begin
            // x already shows the bit at the output end; present the next.
`ifdef SER_LSB_FIRST_EN
            r_sreg <= r_sreg >> 1;
            r_x    <= r_sreg[1];
`else
            r_sreg <= r_sreg << 1;
            r_x    <= r_sreg[WIDTH-2];
`endif
            r_x_valid <= 1'b1;
            r_cnt     <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_x       <= 1'b0;
          r_x_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready = w_ready;
  assign bus.x         = r_x;
  assign bus.x_valid   = r_x_valid;
  assign bus.busy      = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Directed self-checking bench for piso_serializer (WIDTH = 8).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(
    .WIDTH (WIDTH),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit emitted in position i (0 = first on the wire) of word w.
  function automatic logic bit_of(input logic [WIDTH-1:0] w, input int i);
`ifdef SER_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  // Expected sequence for the single-word case, written out by hand.
  logic [7:0] exp_d0;

  initial begin
`ifdef SER_LSB_FIRST_EN
    exp_d0 = 8'b0000_1011;   // first-out bit on the left: 0,0,0,0,1,0,1,1
`else
    exp_d0 = 8'b1101_0000;   // 1,1,0,1,0,0,0,0
`endif

    // ---------------- reset held with din_valid high ----------------
    rst           = 1'b0;
    bus.din       = 8'hAA;
    bus.din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_x",     32'(bus.x),         32'd0);
      check("rst_xv",    32'(bus.x_valid),   32'd0);
      check("rst_busy",  32'(bus.busy),      32'd0);
      check("rst_ready", 32'(bus.din_ready), 32'd0);
    end
    bus.din_valid = 1'b0;
    rst           = 1'b1;
    #1;
    check("idle_ready", 32'(bus.din_ready), 32'd1);

    // ---------------- single word 8'hD0 ----------------
    @(negedge clk);
    bus.din       = 8'hD0;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      check("single_x",     32'(bus.x),         32'(exp_d0[7-i]));
      check("single_xv",    32'(bus.x_valid),   32'd1);
      check("single_busy",  32'(bus.busy),      32'd1);
      check("single_ready", 32'(bus.din_ready), (i == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("single_end_xv",   32'(bus.x_valid), 32'd0);
    check("single_end_busy", 32'(bus.busy),    32'd0);
    check("single_end_x",    32'(bus.x),       32'd0);

    // ---------------- back-to-back 8'hA5, 8'h3C ----------------
    bus.din       = 8'hA5;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("b2b_x",     32'(bus.x),
            32'((i < 8) ? bit_of(8'hA5, i) : bit_of(8'h3C, i - 8)));
      check("b2b_xv",    32'(bus.x_valid),   32'd1);
      check("b2b_ready", 32'(bus.din_ready), (i % 8 == 7) ? 32'd1 : 32'd0);
      if (i == 0) bus.din = 8'h3C;
      if (i == 8) bus.din_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_xv",   32'(bus.x_valid), 32'd0);
    check("b2b_end_busy", 32'(bus.busy),    32'd0);

    // ---------------- stall: 8'hFF offered during 8'h00 ----------------
    bus.din       = 8'h00;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) bus.din = 8'hFF;
      if (i == 8) bus.din_valid = 1'b0;
      check("stall_x",     32'(bus.x),         (i < 8) ? 32'd0 : 32'd1);
      check("stall_xv",    32'(bus.x_valid),   32'd1);
      check("stall_ready", 32'(bus.din_ready), (i == 7 || i == 15) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("stall_end_xv", 32'(bus.x_valid), 32'd0);

    // ---------------- reset mid-word ----------------
    bus.din       = 8'hF0;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      check("mid_x", 32'(bus.x), 32'(bit_of(8'hF0, i)));
    end
    check("mid_xv", 32'(bus.x_valid), 32'd1);
    #2 rst = 1'b0;            // between edges: clears without a clock
    #1;
    check("async_x",     32'(bus.x),         32'd0);
    check("async_xv",    32'(bus.x_valid),   32'd0);
    check("async_busy",  32'(bus.busy),      32'd0);
    check("async_ready", 32'(bus.din_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_ready", 32'(bus.din_ready), 32'd1);
    bus.din       = 8'h81;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      check("post_x",  32'(bus.x),       (i == 0 || i == 7) ? 32'd1 : 32'd0);
      check("post_xv", 32'(bus.x_valid), 32'd1);
    end
    @(negedge clk);
    check("post_end_xv",   32'(bus.x_valid), 32'd0);
    check("post_end_busy", 32'(bus.busy),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
